// File: rtl/svn_seg_scan_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
package svn_seg_pkg;

  // Active-high segment patterns, bit order g..a, indexed by nibble value.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Shown for nibbles above 9 in decimal mode.
  localparam logic [6:0] DASH = 7'h40;

  typedef enum logic {
    GUARD,
    ON
  } state_t;

endpackage

// File: rtl/svn_seg_scan_if.sv
// Host-side inputs and board-side outputs of the segment scanner.
interface svn_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] D;
  logic [NUM_DIGITS-1:0]   DP;
  logic [NUM_DIGITS-1:0]   BLANK;
  logic                    HEX_EN;
  logic                    LOAD;
  logic [7:0]              SEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    FRAME;

  modport master (
    output D, DP, BLANK, HEX_EN, LOAD,
    input  SEG, AN, FRAME
  );

  modport slave (
    input  D, DP, BLANK, HEX_EN, LOAD,
    output SEG, AN, FRAME
  );
endinterface

// File: rtl/svn_seg_dec.sv
// Combinational nibble to 7-segment pattern decoder (active-high, g..a).
module svn_seg_dec
  import svn_seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_en,
  output logic [6:0] pat
);

  // Table lookup, with nibbles above 9 replaced by a dash in decimal mode.
  always_comb begin
    pat = SEG_PAT[nib];
    if (!hex_en && (nib > 4'd9)) pat = DASH;
  end

endmodule

// File: rtl/svn_seg_scan.sv
// Time-multiplexed multi-digit 7-segment driver with guard gaps,
// frame-synchronous display update and leading-zero suppression.
module svn_seg_scan
  import svn_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int GUARD_CYC  = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_BLANK   = 1
) (
  input  logic CLK,
  input  logic RST_N,
  svn_seg_scan_if.slave bus
);

  localparam int PW = $clog2(SLOT_CYC);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SLOT_CYC - 1);
  localparam logic [PW-1:0] P_GEND = PW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0] presc, presc_nx;
  logic [IW-1:0] idx, idx_nx;
  state_t        state, state_nx;

  logic [4*NUM_DIGITS-1:0] sh_d, ds_d;
  logic [NUM_DIGITS-1:0]   sh_dp, ds_dp, sh_bl, ds_bl;
  logic                    sh_hex, ds_hex;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  all_zero;
  logic [3:0]            nib;
  logic [6:0]            pat;
  logic                  lit;
  logic [7:0]            seg_act;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  frame_nx;

  // Next prescaler, digit index and slot state.
  always_comb begin
    presc_nx = (presc == P_LAST) ? '0 : presc + 1'b1;
    idx_nx   = idx;
    if (presc == P_LAST) idx_nx = (idx == I_LAST) ? '0 : idx + 1'b1;
    state_nx = state;
    case (state)
      GUARD:   if (presc == P_GEND) state_nx = ON;
      ON:      if (presc == P_LAST) state_nx = GUARD;
      default: state_nx = GUARD;
    endcase
  end

  // A digit is LZ-dark when it and every more-significant digit are zero.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      all_zero = all_zero & (ds_d[(NUM_DIGITS-1-j)*4 +: 4] == 4'h0);
      lz_mask[NUM_DIGITS-1-j] = all_zero;
    end
    lz_mask[0] = 1'b0;
    if (LZ_BLANK == 0) lz_mask = '0;
  end

  // Pin values are built from the next state so that the output register
  // switches on the same edge as the state register.
  always_comb begin
    nib      = ds_d[{idx_nx, 2'b00} +: 4];
    lit      = (state_nx == ON) && !ds_bl[idx_nx] && !lz_mask[idx_nx];
    seg_act  = lit ? {ds_dp[idx_nx], pat} : '0;
    an_act   = lit ? (NUM_DIGITS'(1) << idx_nx) : '0;
    frame_nx = (presc_nx == P_LAST) && (idx_nx == I_LAST);
  end

  svn_seg_dec u_dec (
    .nib    (nib),
    .hex_en (ds_hex),
    .pat    (pat)
  );

  // Scan FSM with registered, polarity-adjusted pin outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc     <= '0;
      idx       <= '0;
      state     <= GUARD;
      bus.SEG   <= SEG_OFF;
      bus.AN    <= AN_OFF;
      bus.FRAME <= 1'b0;
    end else begin
      presc     <= presc_nx;
      idx       <= idx_nx;
      state     <= state_nx;
      bus.SEG   <= seg_act ^ SEG_OFF;
      bus.AN    <= an_act ^ AN_OFF;
      bus.FRAME <= frame_nx;
    end
  end

  // Shadow capture on LOAD; display copies the old shadow at the frame edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_d   <= '0;
      sh_dp  <= '0;
      sh_bl  <= '0;
      sh_hex <= 1'b0;
      ds_d   <= '0;
      ds_dp  <= '0;
      ds_bl  <= '0;
      ds_hex <= 1'b0;
    end else begin
      if (bus.LOAD) begin
        sh_d   <= bus.D;
        sh_dp  <= bus.DP;
        sh_bl  <= bus.BLANK;
        sh_hex <= bus.HEX_EN;
      end
      if (bus.FRAME) begin
        ds_d   <= sh_d;
        ds_dp  <= sh_dp;
        ds_bl  <= sh_bl;
        ds_hex <= sh_hex;
      end
    end
  end

endmodule
